zb_tx_chip_mod: RTL and testbench

// - ZigBee (IEEE 802.15.4, 2.4 GHz) transmit chip modulator. It is the TX counterpart of the RX CDR/divider chain.
// - Accepts 4-bit symbols over a valid/ready handshake and spreads each one to its 32-chip PN sequence.
// - Emits chips at 2 Mchip/s from the 50 MHz clock (CHIP_DIV=25 clocks per chip).
// - Drives O-QPSK half-sine-shaper inputs: even chips go to I, odd chips go to Q. Each rail holds 2 chip periods, so Q lags I by one chip.

---
 rtl/zb_pkg.sv | 31 +++
 rtl/zb_tx_chip_mod_chip_rate_gen.sv | 42 ++++
 rtl/zb_tx_chip_mod.sv | 156 +++++++++++++++
 tb/tb_zb_tx_chip_mod.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zb_pkg.sv
// ZigBee (802.15.4, 2.4 GHz) shared definitions for the TX modulator and the
// RX despreader: chip-sequence type, modulator state encoding and the
// symbol-to-chip PN spreading function.
package zb_pkg;

  localparam int CHIPS_PER_SYM = 32;

  // Bit k of a chip_seq_t holds chip ck (c0 in bit 0).
  typedef logic [31:0] chip_seq_t;

  typedef enum logic [1:0] {IDLE, SEND, TAIL} tx_state_t;

  // Symbol 0 written as it reads in the standard, c0 first, so bit 31 is c0.
  localparam logic [31:0] PN_SYM0_C0_MSB = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

  // Symbols 1..7 are symbol 0 rotated right by 4n chips, i.e. chip k of
  // symbol n is chip (k - 4n) mod 32 of symbol 0. Symbols 8..15 additionally
  // invert every odd-indexed chip.
  function automatic chip_seq_t pn_chips(input logic [3:0] sym);
    chip_seq_t  seq;
    logic [4:0] src;
    seq = '0;
    for (int k = 0; k < CHIPS_PER_SYM; k++) begin
      src    = 5'(k) - {sym[2:0], 2'b00};
      // ~src == 31 - src maps chip index to the MSB-first literal.
      seq[k] = PN_SYM0_C0_MSB[~src] ^ (sym[3] & k[0]);
    end
    return seq;
  endfunction

endpackage

// File: rtl/zb_tx_chip_mod_chip_rate_gen.sv
// Chip-period divider. Counts 0..CHIP_DIV-1 while enabled and wraps; o_tc is
// high on the last clock of each period. i_clr synchronously returns the
// count to 0 so a new period can be started on any clock.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-low reset
//   i_clr  synchronous clear (has priority over i_en)
//   i_en   advance the counter
//   o_tc   count == CHIP_DIV-1
module chip_rate_gen #(
  parameter int CHIP_DIV = 25,
  parameter int DIV_W    = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign o_tc = (cnt_q == DIV_W'(CHIP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/zb_tx_chip_mod.sv
// ZigBee O-QPSK transmit chip modulator. Accepts 4-bit symbols on a
// valid/ready handshake, spreads each to its 32-chip PN sequence and emits one
// chip every CHIP_DIV clocks. Even chips drive the I rail and odd chips the Q
// rail; each rail holds for two chip periods, so Q lags I by one chip.
// Ports:
//   i_clk        system clock (50 MHz)
//   i_rst        asynchronous active-low reset
//   i_tx_en      transmit enable; low aborts to IDLE on the next clock
//   i_sym_valid  symbol available
//   i_sym        symbol 0..15
//   o_sym_ready  symbol accepted this cycle when i_sym_valid is high
//   o_chip       chip value, valid with o_chip_stb (0 otherwise)
//   o_chip_stb   one-clock pulse at the start of every chip period
//   o_i, o_q     half-sine shaper rail levels
//   o_busy       modulator not idle
module zb_tx_chip_mod
  import zb_pkg::*;
#(
  parameter int CHIP_DIV = 25,
  parameter int DIV_W    = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_en,
  input  logic       i_sym_valid,
  input  logic [3:0] i_sym,
  output logic       o_sym_ready,
  output logic       o_chip,
  output logic       o_chip_stb,
  output logic       o_i,
  output logic       o_q,
  output logic       o_busy
);

  tx_state_t  state_q, state_d;
  logic [4:0] chip_idx_q, chip_idx_d;
  chip_seq_t  chip_reg_q, chip_reg_d;
  logic       chip_q, chip_d;
  logic       stb_q, stb_d;
  logic       rail_i_q, rail_i_d;
  logic       rail_q_q, rail_q_d;

  logic       div_tc, div_clr, div_en;
  logic       last_slot, xfer;
  logic [4:0] chip_idx_nxt;
  chip_seq_t  load_seq;

  chip_rate_gen #(
    .CHIP_DIV (CHIP_DIV),
    .DIV_W    (DIV_W)
  ) u_rate (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (div_clr),
    .i_en  (div_en),
    .o_tc  (div_tc)
  );

  // The only mid-stream acceptance point is the last clock of c31, so a
  // following symbol's c0 lands exactly one chip period after c31.
  assign last_slot   = (state_q == SEND) && (chip_idx_q == 5'd31) && div_tc;
  // Gated by i_rst so ready stays low while reset is asserted.
  assign o_sym_ready = i_rst & i_tx_en & ((state_q == IDLE) | last_slot);
  assign xfer        = i_sym_valid & o_sym_ready;

  assign chip_idx_nxt = chip_idx_q + 5'd1;
  assign load_seq     = pn_chips(i_sym);

  always_comb begin
    state_d    = state_q;
    chip_idx_d = chip_idx_q;
    chip_reg_d = chip_reg_q;
    chip_d     = 1'b0;
    stb_d      = 1'b0;
    rail_i_d   = rail_i_q;
    rail_q_d   = rail_q_q;
    div_clr    = 1'b0;
    div_en     = 1'b0;

    if (!i_tx_en) begin
      state_d    = IDLE;
      chip_idx_d = '0;
      chip_reg_d = '0;
      rail_i_d   = 1'b0;
      rail_q_d   = 1'b0;
      div_clr    = 1'b1;
    end else if (xfer) begin
      // c0 is even, so it goes to I; Q keeps the previous symbol's c31.
      state_d    = SEND;
      chip_idx_d = '0;
      chip_reg_d = load_seq;
      chip_d     = load_seq[0];
      stb_d      = 1'b1;
      rail_i_d   = load_seq[0];
      div_clr    = 1'b1;
    end else begin
      case (state_q)
        SEND: begin
          div_en = 1'b1;
          if (div_tc) begin
            if (chip_idx_q == 5'd31) begin
              state_d  = TAIL;
              rail_i_d = 1'b0;
            end else begin
              chip_idx_d = chip_idx_nxt;
              chip_d     = chip_reg_q[chip_idx_nxt];
              stb_d      = 1'b1;
              if (chip_idx_nxt[0]) begin
                rail_q_d = chip_reg_q[chip_idx_nxt];
              end else begin
                rail_i_d = chip_reg_q[chip_idx_nxt];
              end
            end
          end
        end
        TAIL: begin
          // One extra period so the last Q half-sine completes.
          div_en = 1'b1;
          if (div_tc) begin
            state_d  = IDLE;
            rail_q_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      chip_idx_q <= '0;
      chip_reg_q <= '0;
      chip_q     <= 1'b0;
      stb_q      <= 1'b0;
      rail_i_q   <= 1'b0;
      rail_q_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      chip_idx_q <= chip_idx_d;
      chip_reg_q <= chip_reg_d;
      chip_q     <= chip_d;
      stb_q      <= stb_d;
      rail_i_q   <= rail_i_d;
      rail_q_q   <= rail_q_d;
    end
  end

  assign o_chip     = chip_q;
  assign o_chip_stb = stb_q;
  assign o_i        = rail_i_q;
  assign o_q        = rail_q_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_zb_tx_chip_mod.sv
module tb_zb_tx_chip_mod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_en = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] sym = 4'd0;
  logic       o_sym_ready, o_chip, o_chip_stb, o_i, o_q, o_busy;

  always #10 clk = ~clk;

  zb_tx_chip_mod dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_tx_en     (tx_en),
    .i_sym_valid (valid),
    .i_sym       (sym),
    .o_sym_ready (o_sym_ready),
    .o_chip      (o_chip),
    .o_chip_stb  (o_chip_stb),
    .o_i         (o_i),
    .o_q         (o_q),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // 802.15.4 2.4 GHz chip table, c0 is the leftmost (MSB) character.
  function automatic logic [31:0] pn_word(input int s);
    case (s)
      0:  return 32'b11011001110000110101001000101110;
      1:  return 32'b11101101100111000011010100100010;
      2:  return 32'b00101110110110011100001101010010;
      3:  return 32'b00100010111011011001110000110101;
      4:  return 32'b01010010001011101101100111000011;
      5:  return 32'b00110101001000101110110110011100;
      6:  return 32'b11000011010100100010111011011001;
      7:  return 32'b10011100001101010010001011101101;
      8:  return 32'b10001100100101100000011101111011;
      9:  return 32'b10111000110010010110000001110111;
      10: return 32'b01111011100011001001011000000111;
      11: return 32'b01110111101110001100100101100000;
      12: return 32'b00000111011110111000110010010110;
      13: return 32'b01100000011101111011100011001001;
      14: return 32'b10010110000001110111101110001100;
      default: return 32'b11001001011000000111011110111000;
    endcase
  endfunction

  function automatic logic pn_bit(input int s, input int k);
    logic [31:0] w;
    w = pn_word(s);
    return w[31 - k];
  endfunction

  // Timeline model: a symbol occupies 800 clocks of chips followed by 25
  // clocks of tail unless another symbol is taken at clock 799.
  int   cyc = 0;
  int   m_start = 0;
  int   m_sym = 0;
  bit   m_active = 1'b0;
  logic m_prevq = 1'b0;

  function automatic bit model_ready();
    int e;
    e = cyc - m_start;
    return rst_n && tx_en && (!m_active || e == 799 || e >= 825);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!tx_en) begin
        m_active <= 1'b0;
      end else if (valid && model_ready()) begin
        m_prevq  <= (m_active && (cyc - m_start) == 799) ? pn_bit(m_sym, 31) : 1'b0;
        m_sym    <= int'(sym);
        m_start  <= cyc + 1;
        m_active <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int   e, k;
    logic ei, eq, ec, es, eb;
    e  = cyc - m_start;
    ei = 1'b0; eq = 1'b0; ec = 1'b0; es = 1'b0; eb = 1'b0;
    if (m_active && e < 800) begin
      k  = e / 25;
      es = (e % 25 == 0);
      ec = es ? pn_bit(m_sym, k) : 1'b0;
      eb = 1'b1;
      ei = pn_bit(m_sym, k - (k % 2));
      eq = (k >= 1) ? pn_bit(m_sym, (k % 2 == 1) ? k : k - 1) : m_prevq;
    end else if (m_active && e < 825) begin
      eb = 1'b1;
      eq = pn_bit(m_sym, 31);
    end
    chk("cyc_ready", int'(o_sym_ready), int'(model_ready()));
    chk("cyc_stb",   int'(o_chip_stb), int'(es));
    chk("cyc_chip",  int'(o_chip), int'(ec));
    chk("cyc_i",     int'(o_i), int'(ei));
    chk("cyc_q",     int'(o_q), int'(eq));
    chk("cyc_busy",  int'(o_busy), int'(eb));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [63:0] word64;
    int nstb, last, idx, last_acc;

    // Reset and idle
    #1 rst_n = 1'b0;
    tx_en = 1'b1;
    valid = 1'b0;
    repeat (5) tick();
    chk("rst_ready", int'(o_sym_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    #1 chk("rel_ready", int'(o_sym_ready), 1);
    repeat (100) tick();
    chk("idle_ready", int'(o_sym_ready), 1);
    chk("idle_busy", int'(o_busy), 0);
    $display("txn reset/idle done");

    // Single symbol 0
    valid = 1'b1; sym = 4'd0;
    chk("s0_ready", int'(o_sym_ready), 1);
    tick();
    valid = 1'b0;
    word = '0; nstb = 0;
    for (int rel = 1; rel <= 830; rel++) begin
      if (o_chip_stb) begin
        nstb++;
        word = {word[30:0], o_chip};
      end
      if (rel == 1)   chk("s0_i_on", int'(o_i), 1);
      if (rel == 1)   chk("s0_stb0", int'(o_chip_stb), 1);
      if (rel == 25)  chk("s0_stb_gap", int'(o_chip_stb), 0);
      if (rel == 26)  chk("s0_stb1", int'(o_chip_stb), 1);
      if (rel == 25)  chk("s0_q_pre", int'(o_q), 0);
      if (rel == 26)  chk("s0_q_on", int'(o_q), 1);
      if (rel == 50)  chk("s0_i_hold", int'(o_i), 1);
      if (rel == 51)  chk("s0_i_off", int'(o_i), 0);
      if (rel == 825) chk("s0_busy_tail", int'(o_busy), 1);
      if (rel == 826) chk("s0_busy_idle", int'(o_busy), 0);
      tick();
    end
    chk("s0_nstb", nstb, 32);
    chk("s0_chips", int'(word), int'(32'b1101_1001_1100_0011_0101_0010_0010_1110));
    $display("txn sym0 chips=%08h strobes=%0d", word, nstb);

    // Back-to-back symbol 3 then symbol 12
    valid = 1'b1; sym = 4'd3;
    tick();
    sym = 4'd12;
    word64 = '0; nstb = 0; last = -1;
    for (int rel = 1; rel <= 1630; rel++) begin
      if (rel == 800) chk("b2b_ready_slot", int'(o_sym_ready), 1);
      if (rel == 800) chk("b2b_busy_noidle", int'(o_busy), 1);
      if (rel == 801) valid = 1'b0;
      if (rel == 801) chk("b2b_q_c31", int'(o_q), 1);
      if (o_chip_stb) begin
        if (last >= 0) chk("b2b_spacing", rel - last, 25);
        last = rel;
        nstb++;
        word64 = {word64[62:0], o_chip};
      end
      if (rel == 1625) chk("b2b_tail", int'(o_busy), 1);
      if (rel == 1626) chk("b2b_idle", int'(o_busy), 0);
      tick();
    end
    chk("b2b_nstb", nstb, 64);
    chk("b2b_sym3", int'(word64[63:32]), int'(32'b00100010111011011001110000110101));
    chk("b2b_sym12", int'(word64[31:0]), int'(32'b00000111011110111000110010010110));
    $display("txn b2b chips=%016h strobes=%0d", word64, nstb);

    // Abort at chip 10, then a clean symbol 5
    valid = 1'b1; sym = 4'd7;
    tick();
    valid = 1'b0;
    repeat (255) tick();
    chk("ab_busy_before", int'(o_busy), 1);
    tx_en = 1'b0;
    tick();
    chk("ab_busy", int'(o_busy), 0);
    chk("ab_i", int'(o_i), 0);
    chk("ab_q", int'(o_q), 0);
    chk("ab_stb", int'(o_chip_stb), 0);
    repeat (10) tick();
    chk("ab_ready_off", int'(o_sym_ready), 0);
    tx_en = 1'b1;
    #1 chk("ab_ready_on", int'(o_sym_ready), 1);
    valid = 1'b1; sym = 4'd5;
    tick();
    valid = 1'b0;
    word = '0; nstb = 0;
    for (int rel = 1; rel <= 826; rel++) begin
      if (o_chip_stb) begin
        nstb++;
        word = {word[30:0], o_chip};
      end
      tick();
    end
    chk("ab_s5_nstb", nstb, 32);
    chk("ab_s5_chips", int'(word), int'(32'b00110101001000101110110110011100));
    $display("txn abort then sym5 chips=%08h", word);

    // Asynchronous reset at chip 20
    valid = 1'b1; sym = 4'd9;
    tick();
    valid = 1'b0;
    repeat (510) tick();
    chk("ar_busy_before", int'(o_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(o_busy), 0);
    chk("ar_i", int'(o_i), 0);
    chk("ar_q", int'(o_q), 0);
    chk("ar_stb", int'(o_chip_stb), 0);
    chk("ar_chip", int'(o_chip), 0);
    chk("ar_ready", int'(o_sym_ready), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    nstb = 0;
    for (int rel = 0; rel < 100; rel++) begin
      if (o_chip_stb) nstb++;
      tick();
    end
    chk("ar_no_strobes", nstb, 0);
    $display("txn async reset strobes_after=%0d", nstb);

    // Ready gating with all 16 symbols streamed back to back
    valid = 1'b1; sym = 4'd0; idx = 0; last_acc = -1;
    for (int cy = 0; cy < 14000 && idx < 16; cy++) begin
      automatic bit acc = o_sym_ready;
      tick();
      if (acc) begin
        if (last_acc >= 0) chk("gate_spacing", cy - last_acc, 800);
        last_acc = cy;
        $display("txn gate accept sym=%0d cycle=%0d", idx, cy);
        idx++;
        sym = 4'(idx);
        if (idx == 16) valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk("gate_count", idx, 16);
    repeat (830) tick();
    chk("gate_idle", int'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
